main_memory_ctrl: RTL and testbench

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

---
 rtl/main_memory_ctrl.sv | 120 ++++++++++++
 tb/tb_main_memory_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: fixed-latency 256-bit line store for the dcache; ack_o LATENCY cycles after acceptance.
// One request at a time (busy_o while outstanding); define MEM_ADDR_CHECK_EN to flag misaligned/out-of-range addresses.
`timescale 1ns/1ps
module main_memory_ctrl #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o,
  output logic         err_o
);
  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [7:0]  CNT_LOAD   = 8'(LATENCY - 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 5;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state, state_nxt;
  logic [7:0]         cnt;
  logic               lat_write;
  logic [IDX_W-1:0]   lat_idx;
  logic [255:0]       lat_data;
  logic               lat_err;
  logic [255:0]       mem [DEPTH];

  logic               accept;
  logic               enter_ack;
  logic               addr_err;
  logic               op_write;
  logic               op_err;
  logic [IDX_W-1:0]   op_idx;
  logic [255:0]       op_data;
  logic               unused_addr;

  assign accept    = (state == IDLE) && enable_i;
  assign enter_ack = ((state == WAIT) && (cnt == 8'd0)) || (accept && (LATENCY == 1));

  // With LATENCY=1 the line is touched on the accepting edge, so use the live inputs then.
  assign op_write = (state == IDLE) ? write_i              : lat_write;
  assign op_idx   = (state == IDLE) ? addr_i[5 +: IDX_W]   : lat_idx;
  assign op_data  = (state == IDLE) ? data_i               : lat_data;
  assign op_err   = (state == IDLE) ? addr_err             : lat_err;

  assign unused_addr = ^addr_i;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_err = (addr_i[4:0] != 5'd0) || ({1'b0, addr_i} >= ADDR_LIMIT);
`else
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 1) ? ACK : WAIT;
      WAIT:    if (cnt == 8'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_o  = (state == ACK);
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt       <= 8'd0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_err   <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_LOAD;
      lat_write <= write_i;
      lat_idx   <= addr_i[5 +: IDX_W];
      lat_data  <= data_i;
      lat_err   <= addr_err;
    end else if ((state == WAIT) && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= '0;
    end else if (enter_ack && !op_write) begin
      data_o <= op_err ? '0 : mem[op_idx];
    end
  end

  // Array has no reset; rst_i gating keeps a reset-time edge from committing a write.
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_ack && op_write && !op_err) mem[op_idx] <= op_data;
  end

`ifdef MEM_ADDR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= enter_ack && op_err;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed self-checking bench for main_memory_ctrl (LATENCY=10 instance plus a LATENCY=1 instance).
`timescale 1ns/1ps
module tb_main_memory_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         en = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] din = '0;
  logic         ack, busy, err;
  logic [255:0] dout;

  logic         l1_en = 1'b0, l1_wr = 1'b0;
  logic [31:0]  l1_addr = '0;
  logic [255:0] l1_din = '0;
  logic         l1_ack, l1_busy, l1_err;
  logic [255:0] l1_dout;

  int errors = 0;
  int checks = 0;

  logic [255:0] PAT_A5  = {32{8'hA5}};
  logic [255:0] PAT_5A  = {32{8'h5A}};
  logic [255:0] PAT_OLD = {8{32'h1234_5678}};
  logic [255:0] PAT_NEW = {8{32'hDEAD_BEEF}};
  logic [255:0] PAT_Z   = {16{16'h0F0F}};
  logic [255:0] PAT_Q   = {16{16'hC3C3}};
  logic [255:0] PAT_W   = {8{32'h0BAD_F00D}};
  logic [255:0] PAT_D   = {4{64'h0123_4567_89AB_CDEF}};

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  main_memory_ctrl #(.LATENCY(10), .DEPTH(512)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr), .data_i(din),
    .ack_o(ack), .data_o(dout), .busy_o(busy), .err_o(err)
  );

  main_memory_ctrl #(.LATENCY(1), .DEPTH(16)) u_l1 (
    .clk_i(clk), .rst_i(rst), .enable_i(l1_en), .write_i(l1_wr), .addr_i(l1_addr), .data_i(l1_din),
    .ack_o(l1_ack), .data_o(l1_dout), .busy_o(l1_busy), .err_o(l1_err)
  );

  always #5 clk = ~clk;

  // Present one request to the LATENCY=10 instance; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d);
    if (busy) begin @(posedge clk); #1; end
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk); #1;
    en = 1'b0; din = '0;
  endtask

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ack !== 1'b0)  begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (dout !== '0)   begin errors++; $display("FAIL reset_data: got %h want 0", dout); end
    checks++; if (l1_ack !== 1'b0 || l1_busy !== 1'b0 || l1_dout !== '0)
      begin errors++; $display("FAIL reset_l1: got ack=%b busy=%b want 0/0", l1_ack, l1_busy); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_latency();
    int ack_at = -1;
    int busy_hi = 0;
    issue(1'b1, 32'h40, PAT_A5);
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (ack) begin ack_at = i; break; end
      if (busy) busy_hi++;
    end
    checks++; if (ack_at !== 10) begin errors++; $display("FAIL wr_latency: ack at %0d want 10", ack_at); end
    checks++; if (busy_hi !== 10) begin errors++; $display("FAIL wr_busy_cycles: got %0d want 10", busy_hi); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_at_ack: got %b want 1", busy); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL wr_data_untouched: got %h want 0", dout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", err); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL wr_pulse_end: got ack=%b busy=%b want 0/0", ack, busy); end
  endtask

  task automatic test_read_back();
    int n;
    issue(1'b0, 32'h40, '0);
    wait_ack(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL rd_latency: ack at %0d want 10", n); end
    checks++; if (dout !== PAT_A5) begin errors++; $display("FAIL rd_data_at_ack: got %h want %h", dout, PAT_A5); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (dout !== PAT_A5) begin errors++; $display("FAIL rd_data_hold: got %h want %h", dout, PAT_A5); end
    issue(1'b1, 32'h60, PAT_5A);
    wait_ack(n);
    checks++; if (dout !== PAT_A5) begin errors++; $display("FAIL rd_hold_over_write: got %h want %h", dout, PAT_A5); end
    @(posedge clk); #1;
  endtask

  task automatic test_hold_enable();
    int acks = 0;
    int t0 = -1, t1 = -1;
    logic [255:0] d0 = '0, d1 = '0;
    logic busy_gap = 1'b1;
    int extra = 0;
    en = 1'b1; wr = 1'b0; addr = 32'h40;
    for (int i = 0; i <= 23; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        if (acks == 0) begin t0 = i; d0 = dout; end
        else if (acks == 1) begin t1 = i; d1 = dout; end
        acks++;
      end
      if (i == 11) busy_gap = busy;
      if (i == 5)  addr = 32'h60;
      if (i == 15) addr = 32'h40;
    end
    en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ack) extra++;
    end
    checks++; if (acks !== 2) begin errors++; $display("FAIL hold_ack_count: got %0d want 2", acks); end
    checks++; if (t0 !== 10) begin errors++; $display("FAIL hold_first_ack: at %0d want 10", t0); end
    checks++; if (t1 !== 22) begin errors++; $display("FAIL hold_second_ack: at %0d want 22", t1); end
    checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL hold_idle_gap: busy %b want 0", busy_gap); end
    checks++; if (d0 !== PAT_A5) begin errors++; $display("FAIL hold_first_data: got %h want %h", d0, PAT_A5); end
    checks++; if (d1 !== PAT_5A) begin errors++; $display("FAIL hold_second_data: got %h want %h", d1, PAT_5A); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL hold_extra_ack: got %0d want 0", extra); end
  endtask

  task automatic test_reset_abort();
    int n;
    int late_acks = 0;
    issue(1'b1, 32'h80, PAT_OLD);
    wait_ack(n);
    issue(1'b1, 32'h80, PAT_NEW);
    repeat (4) begin @(posedge clk); #1; end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dout !== '0)
      begin errors++; $display("FAIL abort_async_clear: got ack=%b busy=%b err=%b data=%h want all 0", ack, busy, err, dout); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0 || busy !== 1'b0 || dout !== '0)
      begin errors++; $display("FAIL abort_held: got ack=%b busy=%b data=%h want all 0", ack, busy, dout); end
    #3 rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ack) late_acks++;
    end
    checks++; if (late_acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", late_acks); end
    issue(1'b0, 32'h80, '0);
    wait_ack(n);
    checks++; if (dout !== PAT_OLD) begin errors++; $display("FAIL abort_old_data: got %h want %h", dout, PAT_OLD); end
  endtask

  task automatic test_addr_alias();
    int n;
    issue(1'b1, 32'h0, PAT_Z);
    wait_ack(n);
    issue(1'b1, 32'h4000, PAT_Q);
    wait_ack(n);
    checks++; if (err !== CHK) begin errors++; $display("FAIL range_err: got %b want %b", err, CHK); end
    issue(1'b0, 32'h0, '0);
    wait_ack(n);
    checks++; if (dout !== (CHK ? PAT_Z : PAT_Q))
      begin errors++; $display("FAIL range_alias_line0: got %h want %h", dout, CHK ? PAT_Z : PAT_Q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_clean_err: got %b want 0", err); end
    issue(1'b1, 32'h44, PAT_W);
    wait_ack(n);
    checks++; if (err !== CHK) begin errors++; $display("FAIL misalign_err: got %b want %b", err, CHK); end
    issue(1'b0, 32'h40, '0);
    wait_ack(n);
    checks++; if (dout !== (CHK ? PAT_A5 : PAT_W))
      begin errors++; $display("FAIL misalign_line: got %h want %h", dout, CHK ? PAT_A5 : PAT_W); end
`ifdef MEM_ADDR_CHECK_EN
    issue(1'b0, 32'h4000, '0);
    wait_ack(n);
    checks++; if (dout !== '0 || err !== 1'b1)
      begin errors++; $display("FAIL range_read_zero: got err=%b data=%h want 1/0", err, dout); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_latency_one();
    l1_en = 1'b1; l1_wr = 1'b1; l1_addr = 32'h20; l1_din = PAT_D;
    @(posedge clk); #1;
    checks++; if (l1_ack !== 1'b1 || l1_busy !== 1'b1)
      begin errors++; $display("FAIL l1_ack_next: got ack=%b busy=%b want 1/1", l1_ack, l1_busy); end
    l1_wr = 1'b0; l1_din = '0;
    @(posedge clk); #1;
    checks++; if (l1_ack !== 1'b0 || l1_busy !== 1'b0)
      begin errors++; $display("FAIL l1_no_back_to_back: got ack=%b busy=%b want 0/0", l1_ack, l1_busy); end
    @(posedge clk); #1;
    checks++; if (l1_ack !== 1'b1) begin errors++; $display("FAIL l1_second_ack: got %b want 1", l1_ack); end
    checks++; if (l1_dout !== PAT_D) begin errors++; $display("FAIL l1_read: got %h want %h", l1_dout, PAT_D); end
    l1_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (l1_ack !== 1'b0 || l1_err !== 1'b0)
      begin errors++; $display("FAIL l1_idle: got ack=%b err=%b want 0/0", l1_ack, l1_err); end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_back();
    test_hold_enable();
    test_reset_abort();
    test_addr_alias();
    test_latency_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
